// File: rtl/mem_region_mapper.sv
// mem_region_mapper: decodes the CPU address into NREG prioritised regions,
// issues one write strobe per CPU write and returns registered read data
// with a ready handshake. Each region has its own base, mask and wait states.
//
// Packed parameters place region 0 in the least-significant field, so the
// rightmost entry of each default concatenation below is region 0.
//
// Optional feature: define MEM_REGION_MAPPER_FAULT_EN to add a sticky
// fault flag and fault address for unmapped accesses and dropped writes.
module mem_region_mapper #(
    parameter int                       ADDR_W       = 16,
    parameter int                       DATA_W       = 8,
    parameter int                       NREG         = 4,
    parameter logic [NREG*ADDR_W-1:0]   REG_BASE     = {16'h0000, 16'hE000, 16'hB000, 16'h0000},
    parameter logic [NREG*ADDR_W-1:0]   REG_MASK     = {16'h0000, 16'hE000, 16'hF000, 16'hC000},
    parameter logic [NREG*4-1:0]        REG_WAIT     = {4'd0, 4'd1, 4'd0, 4'd0},
    parameter logic [NREG-1:0]          REG_WRITABLE = 4'b0011,
    parameter logic [DATA_W-1:0]        DEFAULT_DATA = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_ce,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_wr,
    input  logic [DATA_W-1:0]        cpu_dout,
    output logic [DATA_W-1:0]        cpu_din,
    output logic                     cpu_ready,
    output logic [NREG-1:0]          reg_sel,
    output logic [NREG-1:0]          reg_wren,
    output logic [ADDR_W-1:0]        reg_addr,
    output logic [DATA_W-1:0]        reg_wdata,
    input  logic [NREG*DATA_W-1:0]   reg_rdata
`ifdef MEM_REGION_MAPPER_FAULT_EN
    ,
    output logic                     fault,
    output logic [ADDR_W-1:0]        fault_addr,
    input  logic                     fault_clr
`endif
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic              ce_q;
    logic              start;
    logic [NREG-1:0]   hit;
    logic              hit_any;
    logic [IDX_W-1:0]  hit_idx;
    logic [NREG-1:0]   hit_onehot;
    logic [IDX_W-1:0]  idx_q;
    logic              hit_q;
    logic              wr_q;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_load;

    assign start = cpu_ce & ~ce_q;

    // Per-region address match; a zero mask disables the region
    always_comb begin
        hit = '0;
        for (int k = 0; k < NREG; k++) begin
            hit[k] = (REG_MASK[k*ADDR_W +: ADDR_W] != '0) &&
                     ((cpu_addr & REG_MASK[k*ADDR_W +: ADDR_W]) ==
                      (REG_BASE[k*ADDR_W +: ADDR_W] & REG_MASK[k*ADDR_W +: ADDR_W]));
        end
    end

    // Priority encoder: the lowest-index hit wins on overlap
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if (hit[k]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign hit_onehot = hit_any ? (NREG'(1) << hit_idx) : '0;
    assign wait_load  = REG_WAIT[idx_q*4 +: 4];

    // Access sequencer: latch on the ce rising edge, strobe, wait, return data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ce_q      <= 1'b0;
            cpu_din   <= DEFAULT_DATA;
            cpu_ready <= 1'b1;
            reg_sel   <= '0;
            reg_wren  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            wr_q      <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            ce_q <= cpu_ce;
            case (state)
                IDLE: begin
                    if (start) begin
                        reg_addr  <= cpu_addr;
                        reg_wdata <= cpu_dout;
                        wr_q      <= cpu_wr;
                        idx_q     <= hit_idx;
                        hit_q     <= hit_any;
                        reg_sel   <= hit_onehot;
                        cpu_ready <= 1'b0;
                        if (hit_any) begin
                            // Strobe is raised here so it is high for the ACCESS cycle only
                            reg_wren <= cpu_wr ? (hit_onehot & REG_WRITABLE) : '0;
                            state    <= ACCESS;
                        end else begin
                            cpu_din <= DEFAULT_DATA;
                            state   <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    reg_wren <= '0;
                    wait_cnt <= wait_load;
                    state    <= (wait_load != 4'd0) ? WAIT : DONE;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (hit_q && !wr_q) begin
                        cpu_din <= reg_rdata[idx_q*DATA_W +: DATA_W];
                    end
                    cpu_ready <= 1'b1;
                    reg_sel   <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_REGION_MAPPER_FAULT_EN
    logic new_fault;

    assign new_fault = (state == DONE) && (!hit_q || (wr_q && !REG_WRITABLE[idx_q]));

    // Sticky fault capture: first address kept; a same-cycle new fault beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (new_fault) begin
            if (!fault || fault_clr) begin
                fault      <= 1'b1;
                fault_addr <= reg_addr;
            end
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_region_mapper.sv
// Scoreboard bench for mem_region_mapper: stimulus pushes expected
// completions and write strobes, a negedge monitor pops and compares them.
module tb_mem_region_mapper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_ce = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic [3:0]  reg_sel;
    logic [3:0]  reg_wren;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [31:0] reg_rdata = {8'h33, 8'h77, 8'hA1, 8'h5A};
`ifdef MEM_REGION_MAPPER_FAULT_EN
    logic        fault;
    logic [15:0] fault_addr;
    logic        fault_clr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int c0 = 0;

    typedef struct {
        logic [7:0] din;
        int         done_cyc;
    } rd_exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          at_cyc;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    mem_region_mapper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_wr    (cpu_wr),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_ready (cpu_ready),
        .reg_sel   (reg_sel),
        .reg_wren  (reg_wren),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
`ifdef MEM_REGION_MAPPER_FAULT_EN
        ,
        .fault      (fault),
        .fault_addr (fault_addr),
        .fault_clr  (fault_clr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Raise ce just after a clock edge; that edge is cycle c0
    task automatic begin_acc(input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr = a;
        cpu_wr   = w;
        cpu_dout = d;
        cpu_ce   = 1'b1;
        c0       = cyc;
    endtask

    // Advance to the falling edge that follows clock edge c0+k
    task automatic wait_to(input int k);
        do @(negedge clk); while (cyc < c0 + k);
    endtask

    task automatic push_rd(input logic [7:0] din, input int lat);
        rd_q.push_back('{din: din, done_cyc: c0 + lat});
    endtask

    task automatic push_wr(input logic [3:0] mask, input logic [15:0] a, input logic [7:0] d);
        wr_q.push_back('{mask: mask, addr: a, wdata: d, at_cyc: c0 + 1});
    endtask

    // Monitor: completions on ready rising, strobes whenever wren is nonzero
    logic rdy_prev = 1'b1;
    always @(negedge clk) begin : mon
        rd_exp_t re;
        wr_exp_t we;
        if (cpu_ready && !rdy_prev) begin
            if (rd_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                re = rd_q.pop_front();
                check("rd_data", cpu_din, re.din);
                check("rd_latency", cyc, re.done_cyc);
            end
        end
        if (reg_wren != 4'b0000) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wren", reg_wren, 32'd0);
            end else begin
                we = wr_q.pop_front();
                check("wren_mask", reg_wren, we.mask);
                check("wren_addr", reg_addr, we.addr);
                check("wren_wdata", reg_wdata, we.wdata);
                check("wren_cycle", cyc, we.at_cyc);
            end
        end
        rdy_prev <= cpu_ready;
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cpu_ready, 1);
        check("rst_din", cpu_din, 8'h00);
        check("rst_sel", reg_sel, 4'b0000);
        check("rst_wren", reg_wren, 4'b0000);
        check("rst_addr", reg_addr, 16'h0000);
        check("rst_wdata", reg_wdata, 8'h00);
`ifdef MEM_REGION_MAPPER_FAULT_EN
        check("rst_fault", fault, 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Read region 0; bus changes after the latch must not matter
        begin_acc(16'h1234, 1'b0, 8'h00);
        push_rd(8'h5A, 3);
        wait_to(1);
        check("rd0_ready_low", cpu_ready, 0);
        cpu_addr = 16'h8000;
        cpu_wr   = 1'b1;
        wait_to(2);
        check("rd0_sel", reg_sel, 4'b0001);
        check("rd0_addr", reg_addr, 16'h1234);
        cpu_ce = 1'b0;
        wait_to(6);

        // Write region 1
        begin_acc(16'hB010, 1'b1, 8'hC3);
        push_wr(4'b0010, 16'hB010, 8'hC3);
        push_rd(8'h5A, 3);
        wait_to(2);
        cpu_ce = 1'b0;
        wait_to(6);

        // Read region 2 with one wait state
        begin_acc(16'hE000, 1'b0, 8'h00);
        push_rd(8'h77, 4);
        wait_to(2);
        check("rd2_sel", reg_sel, 4'b0100);
        cpu_ce = 1'b0;
        wait_to(7);

        // Write to read-only region 2 is dropped
        begin_acc(16'hE000, 1'b1, 8'hEE);
        push_rd(8'h77, 4);
        wait_to(2);
        cpu_ce = 1'b0;
        wait_to(5);
`ifdef MEM_REGION_MAPPER_FAULT_EN
        check("ro_fault", fault, 1);
        check("ro_fault_addr", fault_addr, 16'hE000);
        @(posedge clk);
        #1 fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        @(negedge clk);
        check("clr_fault", fault, 0);
        check("clr_fault_addr", fault_addr, 16'h0000);
`endif
        wait_to(8);

        // Unmapped read
        begin_acc(16'h8000, 1'b0, 8'h00);
        push_rd(8'h00, 2);
        wait_to(1);
        check("um_sel", reg_sel, 4'b0000);
        check("um_ready_low", cpu_ready, 0);
        wait_to(2);
        cpu_ce = 1'b0;
        wait_to(3);
`ifdef MEM_REGION_MAPPER_FAULT_EN
        check("um_fault", fault, 1);
        check("um_fault_addr", fault_addr, 16'h8000);
`endif
        wait_to(6);

        // Write region 0
        begin_acc(16'h3000, 1'b1, 8'h42);
        push_wr(4'b0001, 16'h3000, 8'h42);
        push_rd(8'h00, 3);
        wait_to(2);
        cpu_ce = 1'b0;
        wait_to(6);

        // Reset during the ACCESS cycle of a write
        begin_acc(16'h1234, 1'b1, 8'h99);
        @(posedge clk);
        #1;
        check("pre_rst_wren", reg_wren, 4'b0001);
        rst_n  = 1'b0;
        cpu_ce = 1'b0;
        #1;
        check("mid_rst_wren", reg_wren, 4'b0000);
        check("mid_rst_ready", cpu_ready, 1);
        check("mid_rst_din", cpu_din, 8'h00);
        check("mid_rst_sel", reg_sel, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = cyc;
        wait_to(8);
        check("post_rst_ready", cpu_ready, 1);

        // ce held high for 8 clk gives one access; a new rise gives another
        begin_acc(16'h2000, 1'b0, 8'h00);
        push_rd(8'h5A, 3);
        wait_to(8);
        cpu_ce = 1'b0;
        wait_to(10);
        begin_acc(16'hB123, 1'b0, 8'h00);
        push_rd(8'hA1, 3);
        wait_to(2);
        cpu_ce = 1'b0;
        wait_to(8);

        check("rd_queue_empty", rd_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
